// File: rtl/lcd_scanout.sv
// lcd_scanout: video timing generator with centred, integer-scaled scanout
// of a 2-bit framebuffer. Selects the NTSC or PAL vertical total per frame.
module lcd_scanout #(
    parameter int CE_DIV    = 4,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP_NTSC = 33,
    parameter int V_BP_PAL  = 83,
    parameter int SRC_W     = 96,
    parameter int SRC_H     = 64,
    parameter int SCALE     = 5,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        pal,
    output logic [12:0] fb_addr,
    input  logic [1:0]  fb_data,
    output logic        ce_pix,
    output logic        hs,
    output logic        vs,
    output logic        hblank,
    output logic        vblank,
    output logic        de,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT_NTSC = V_ACTIVE + V_FP + V_SYNC + V_BP_NTSC;
    localparam int VT_PAL  = V_ACTIVE + V_FP + V_SYNC + V_BP_PAL;
    localparam int VT_MAX  = (VT_PAL > VT_NTSC) ? VT_PAL : VT_NTSC;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(VT_MAX);
    localparam int CW      = $clog2(CE_DIV);
    localparam int SUBW    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int XSW     = $clog2(SRC_W + 1);
    localparam int YSW     = $clog2(SRC_H + 1);
    localparam int AW      = 13;
    localparam int X0      = (H_ACTIVE - SRC_W * SCALE) / 2;
    localparam int X1      = X0 + SRC_W * SCALE;
    localparam int Y0      = (V_ACTIVE - SRC_H * SCALE) / 2;
    localparam int Y1      = Y0 + SRC_H * SCALE;

    logic [CW-1:0]   ce_cnt_q, ce_cnt_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic            pal_q, pal_d;
    logic [SUBW-1:0] xsub_q, xsub_d;
    logic [XSW-1:0]  xsrc_q, xsrc_d;
    logic [SUBW-1:0] ysub_q, ysub_d;
    logic [YSW-1:0]  ysrc_q, ysrc_d;
    logic [AW-1:0]   row_base_q, row_base_d;
    logic [AW-1:0]   addr_hold_q, addr_hold_d;
    logic            hs_q, hs_d, vs_q, vs_d;
    logic            hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
    logic [7:0]      pix_q, pix_d;
    logic            origin_q, origin_d;

    logic            ce, line_end, frame_end;
    logic            hwin, vwin, win, h_act, v_act;
    logic [AW-1:0]   addr_now;
    logic [7:0]      shade;

    // Pixel-enable divider and raster counters; pal is latched only at frame wrap
    always_comb begin
        ce        = (ce_cnt_q == CW'(CE_DIV - 1));
        ce_cnt_d  = ce ? '0 : ce_cnt_q + 1'b1;
        line_end  = (hcnt_q == HW'(H_TOTAL - 1));
        frame_end = line_end &&
                    (vcnt_q == (pal_q ? VW'(VT_PAL - 1) : VW'(VT_NTSC - 1)));
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        pal_d     = pal_q;
        if (ce) begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end) begin
                vcnt_d = frame_end ? '0 : vcnt_q + 1'b1;
            end
            if (frame_end) begin
                pal_d = pal;
            end
        end
    end

    // Multiplier-free source coordinates: sub-pixel counters step the source
    // column/row, and the row base accumulates SRC_W per source row
    always_comb begin
        hwin       = (hcnt_q >= HW'(X0)) && (hcnt_q < HW'(X1));
        vwin       = (vcnt_q >= VW'(Y0)) && (vcnt_q < VW'(Y1));
        win        = hwin && vwin;
        addr_now   = row_base_q + AW'(xsrc_q);
        xsub_d     = xsub_q;
        xsrc_d     = xsrc_q;
        ysub_d     = ysub_q;
        ysrc_d     = ysrc_q;
        row_base_d = row_base_q;
        addr_hold_d = addr_hold_q;
        if (ce) begin
            if (win) begin
                addr_hold_d = addr_now;
            end
            if (line_end) begin
                xsub_d = '0;
                xsrc_d = '0;
            end else if (hwin) begin
                if (xsub_q == SUBW'(SCALE - 1)) begin
                    xsub_d = '0;
                    xsrc_d = xsrc_q + 1'b1;
                end else begin
                    xsub_d = xsub_q + 1'b1;
                end
            end
            if (frame_end) begin
                ysub_d     = '0;
                ysrc_d     = '0;
                row_base_d = '0;
            end else if (line_end && vwin) begin
                if (ysub_q == SUBW'(SCALE - 1)) begin
                    ysub_d     = '0;
                    ysrc_d     = ysrc_q + 1'b1;
                    row_base_d = row_base_q + AW'(SRC_W);
                end else begin
                    ysub_d = ysub_q + 1'b1;
                end
            end
        end
    end

    // Stage-0 timing decode registered with the fetched colour so that
    // syncs, blanking and data leave together one pixel behind the counters
    always_comb begin
        h_act = (hcnt_q < HW'(H_ACTIVE));
        v_act = (vcnt_q < VW'(V_ACTIVE));
        unique case (fb_data)
            2'd0:    shade = 8'hFF;
            2'd1:    shade = 8'hAA;
            2'd2:    shade = 8'h55;
            default: shade = 8'h00;
        endcase
        hs_d     = hs_q;
        vs_d     = vs_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        de_d     = de_q;
        pix_d    = pix_q;
        origin_d = origin_q;
        if (ce) begin
            hs_d = ((hcnt_q >= HW'(H_ACTIVE + H_FP)) &&
                    (hcnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
            vs_d = ((vcnt_q >= VW'(V_ACTIVE + V_FP)) &&
                    (vcnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
            hblank_d = ~h_act;
            vblank_d = ~v_act;
            de_d     = h_act && v_act;
            pix_d    = (win && h_act && v_act) ? shade : 8'h00;
            origin_d = (hcnt_q == '0) && (vcnt_q == '0);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ce_cnt_q    <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            pal_q       <= 1'b0;
            xsub_q      <= '0;
            xsrc_q      <= '0;
            ysub_q      <= '0;
            ysrc_q      <= '0;
            row_base_q  <= '0;
            addr_hold_q <= '0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            hblank_q    <= 1'b1;
            vblank_q    <= 1'b1;
            de_q        <= 1'b0;
            pix_q       <= '0;
            origin_q    <= 1'b0;
        end else begin
            ce_cnt_q    <= ce_cnt_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            pal_q       <= pal_d;
            xsub_q      <= xsub_d;
            xsrc_q      <= xsrc_d;
            ysub_q      <= ysub_d;
            ysrc_q      <= ysrc_d;
            row_base_q  <= row_base_d;
            addr_hold_q <= addr_hold_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            de_q        <= de_d;
            pix_q       <= pix_d;
            origin_q    <= origin_d;
        end
    end

    // The address tracks the counters inside the window and holds outside it
    assign fb_addr     = win ? addr_now : addr_hold_q;
    assign ce_pix      = ce;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign r           = pix_q;
    assign g           = pix_q;
    assign b           = pix_q;
    assign frame_start = ce && origin_q;

endmodule

// File: doc/lcd_scanout.md
# lcd_scanout

Parametrised video timing generator and LCD scanout for the Pokemon Mini core. It generates pixel enable, sync, blank and data-enable timing for a configurable raster. It centres the 96x64 2-bit LCD framebuffer in that raster with integer scaling and drives the emu-level VGA_* / CE_PIXEL outputs. It replaces fixed-timing video generation inside pokemon_mini: it reads the framebuffer RAM through a 1-cycle-latency read port and adds NTSC/PAL vertical-total selection.

## Interface
Parameters:
- CE_DIV, 4: clk_sys cycles per pixel; legal values are 2 and above.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal pixel counts.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2: vertical line counts.
- V_BP_NTSC, 33 / V_BP_PAL, 83: vertical back porch per mode.
- SRC_W, 96 / SRC_H, 64: framebuffer size.
- SCALE, 5: integer magnification. Legal only when SRC_W*SCALE ≤ H_ACTIVE and SRC_H*SCALE ≤ V_ACTIVE.
- SYNC_POL, 0: sync active level; 0 means active-low.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- pal  in  1  0 = NTSC vertical total, 1 = PAL vertical total.
- fb_addr  out  13  framebuffer read address, y*SRC_W + x.
- fb_data  in  2  shade at fb_addr, valid one clk_sys after fb_addr changes.
- ce_pix  out  1  one-clk_sys pulse every CE_DIV cycles.
- hs, vs  out  1  syncs, at SYNC_POL level when active.
- hblank, vblank, de  out  1  blanking flags; de = ~(hblank|vblank).
- r, g, b  out  8 each  pixel colour.
- frame_start  out  1  one-clk_sys pulse marking the first ce of line 0, pixel 0.

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 800 at defaults.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 525 for NTSC and 575 for PAL.
- CE divider: counts 0..CE_DIV-1; ce_pix is asserted when the count is CE_DIV-1.
- hcnt and vcnt advance only on ce_pix.
  - hcnt wraps at H_TOTAL-1.
  - vcnt increments on the hcnt wrap and itself wraps at V_TOTAL-1.
- Stage 0, counter domain:
  - active = hcnt < H_ACTIVE and vcnt < V_ACTIVE.
  - hsync region: H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync region: V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC.
- Window: X0 = (H_ACTIVE-SRC_W*SCALE)/2 and Y0 = (V_ACTIVE-SRC_H*SCALE)/2, both 80 at defaults. A pixel is in the window when X0 ≤ hcnt < X0+SRC_W*SCALE and the matching vertical condition holds.
- Source coordinate generation uses no multiplier:
  - xsub counts 0..SCALE-1 inside the window and increments xsrc on wrap; both clear at hcnt = H_TOTAL-1.
  - ysub and ysrc do the same per line inside the window; both clear at frame wrap.
  - fb_addr = row_base + xsrc, where row_base is incremented by SRC_W each time ysrc increments.
  - fb_addr holds its last value outside the window.
- Shade map, applied equally to r, g and b: 0→8'hFF, 1→8'hAA, 2→8'h55, 3→8'h00. Active pixels outside the window output 8'h00. Blanked pixels output 8'h00.
- Stage 1: on the ce_pix after fb_addr is issued, register the colour together with the stage-0 hs, vs, hblank, vblank and de. Outputs therefore lag the counters by exactly one pixel, and sync and data stay aligned.
- pal is sampled only at the frame wrap (vcnt = V_TOTAL-1 and hcnt = H_TOTAL-1 on ce). A mid-frame change takes effect on the next frame and never truncates the current one.

## Timing
- Reset values:
  - Outputs: ce_pix=0, hs=vs=~SYNC_POL (inactive), hblank=vblank=1, de=0, r=g=b=0, frame_start=0, fb_addr=0.
  - Internal: counters 0, pal latch 0 (NTSC).
- The first ce_pix occurs CE_DIV clk_sys cycles after reset deasserts.
- frame_start pulses in the same cycle as the first output of pixel (0,0): the second ce_pix after reset and every V_TOTAL*H_TOTAL pixels thereafter.
- Read latency: fb_data is sampled CE_DIV-1 cycles after fb_addr updates, which requires CE_DIV ≥ 2.
- Reset asserted mid-frame: every output returns to its reset value on the next clk_sys edge and the raster restarts from (0,0).

## Test plan
- Reset, then count: first ce_pix at cycle 4; ce_pix period 4; hs low for 96 pixels per 800; frame length 525*800*4 clk_sys.
- pal=1 held: second frame lasts 575 lines and vs is low at lines 490-491. Toggle pal at line 200 and check that the current frame still completes at its old total.
- Framebuffer model filled with shade = (x+y)&3, 1-cycle latency:
  - Output pixel (80,80) is FF; (85,80) is AA; (80,85) is AA.
  - Output pixel (559,399) shows shade (95+63)&3 = 2, i.e. 55.
  - Pixels (79,80) and (560,80) are 00 with de=1.
- fb_addr sequence on line 80: 0 for five pixels, then 1, … up to 95. Line 85 starts at 96. The last window line ends at 6143.
- Alignment: at every ce_pix, de=1 only for 640x480 and colour is nonzero only when de=1. hblank and hs transitions occur exactly one pixel after the matching hcnt value.
- Reset asserted at line 300, pixel 123, for one cycle: next cycle outputs are at reset values, and frame_start arrives after 2 ce_pix.
